// File: rtl/demux_stream_1_to_n.sv
// Registered 1-to-N stream demux with manual or round-robin routing.
// Each channel owns a holding register with its own valid/ready handshake.
module demux_stream_1_to_n #(
    parameter int DATA_WIDTH = 5,
    parameter int NUM_CH     = 30,
    parameter int SEL_WIDTH  = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mode,
    input  logic [SEL_WIDTH-1:0]         sel,
    input  logic                         clear_ptr,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic                         din_valid,
    output logic                         din_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] dout,
    output logic [NUM_CH-1:0]            dout_valid,
    input  logic [NUM_CH-1:0]            dout_ready,
    output logic [SEL_WIDTH-1:0]         ptr,
    output logic                         frame_done,
    output logic                         sel_err
);

    localparam logic [SEL_WIDTH:0]   CH_COUNT = (SEL_WIDTH + 1)'(NUM_CH);
    localparam logic [SEL_WIDTH-1:0] LAST_CH  = SEL_WIDTH'(NUM_CH - 1);

    logic [SEL_WIDTH-1:0] target;
    logic                 in_range;
    logic [NUM_CH-1:0]    hit;
    logic [NUM_CH-1:0]    drain;
    logic                 accept;

    // Resolve the target channel and its one-hot select; none when out of range
    always_comb begin
        target   = mode ? ptr : sel;
        in_range = {1'b0, target} < CH_COUNT;
        hit      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            hit[k] = in_range && (target == SEL_WIDTH'(k));
        end
    end

    assign drain     = dout_valid & dout_ready;
    // Stall only when the selected channel is full and not draining;
    // out-of-range beats are always sunk
    assign din_ready = ~|(hit & dout_valid & ~dout_ready);
    assign accept    = din_valid & din_ready;

    // Per-channel holding registers: load wins over drain, data held after drain
    always_ff @(posedge clk) begin
        if (reset) begin
            dout       <= '0;
            dout_valid <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (accept && hit[k]) begin
                    dout[k*DATA_WIDTH +: DATA_WIDTH] <= din;
                    dout_valid[k]                    <= 1'b1;
                end else if (drain[k]) begin
                    dout_valid[k] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer: clear beats increment, wrap emits a one-cycle pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            frame_done <= 1'b0;
        end else if (clear_ptr) begin
            ptr        <= '0;
            frame_done <= 1'b0;
        end else if (accept && mode) begin
            ptr        <= (ptr == LAST_CH) ? '0 : ptr + 1'b1;
            frame_done <= (ptr == LAST_CH);
        end else begin
            frame_done <= 1'b0;
        end
    end

    // Sticky flag for beats dropped because of an invalid manual select
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err <= 1'b0;
        end else if (accept && !mode && !in_range) begin
            sel_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_demux_stream_1_to_n.sv
// Directed bench for demux_stream_1_to_n: vector table for manual routing,
// hand sequences for reset, round-robin, clear/wrap overlap and mid-run reset.
module tb_demux_stream_1_to_n;

    localparam int DW = 5;
    localparam int NC = 30;
    localparam int SW = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              mode;
    logic [SW-1:0]     sel;
    logic              clear_ptr;
    logic [DW-1:0]     din;
    logic              din_valid;
    logic              din_ready;
    logic [NC*DW-1:0]  dout;
    logic [NC-1:0]     dout_valid;
    logic [NC-1:0]     dout_ready;
    logic [SW-1:0]     ptr;
    logic              frame_done;
    logic              sel_err;

    int n_chk  = 0;
    int n_fail = 0;

    demux_stream_1_to_n #(
        .DATA_WIDTH(DW),
        .NUM_CH    (NC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .sel       (sel),
        .clear_ptr (clear_ptr),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .ptr       (ptr),
        .frame_done(frame_done),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          mode;
        logic [SW-1:0] sel;
        logic [DW-1:0] din;
        logic          dv;
        logic [NC-1:0] rdy;
        logic          exp_ready;
        int            ch;
        logic          exp_v;
        logic [DW-1:0] exp_d;
        logic          exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] ch_data(input int k);
        return dout[k*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_ready(input string name, input logic exp);
        @(negedge clk);
        chk(name, din_ready, exp);
    endtask

    initial begin
        vecs[0] = '{1'b0, 5'd3,  5'h0A, 1'b1, 30'h0, 1'b1, 3,  1'b1, 5'h0A, 1'b0};
        vecs[1] = '{1'b0, 5'd29, 5'h15, 1'b1, 30'h0, 1'b1, 29, 1'b1, 5'h15, 1'b0};
        vecs[2] = '{1'b0, 5'd3,  5'h07, 1'b1, 30'h0, 1'b0, 3,  1'b1, 5'h0A, 1'b0};
        vecs[3] = '{1'b0, 5'd3,  5'h07, 1'b1, 30'h8, 1'b1, 3,  1'b1, 5'h07, 1'b0};
        vecs[4] = '{1'b0, 5'd3,  5'h00, 1'b0, 30'h8, 1'b1, 3,  1'b0, 5'h07, 1'b0};
        vecs[5] = '{1'b0, 5'd30, 5'h1F, 1'b1, 30'h0, 1'b1, 29, 1'b1, 5'h15, 1'b1};
        vecs[6] = '{1'b0, 5'd5,  5'h03, 1'b1, 30'h0, 1'b1, 5,  1'b1, 5'h03, 1'b1};
        vecs[7] = '{1'b0, 5'd31, 5'h1C, 1'b0, 30'h0, 1'b1, 5,  1'b1, 5'h03, 1'b1};

        reset      = 1'b1;
        mode       = 1'b0;
        sel        = '0;
        clear_ptr  = 1'b0;
        din        = 5'h1F;
        din_valid  = 1'b1;
        dout_ready = '0;

        // reset held two cycles with a valid beat presented
        tick();
        tick();
        chk("reset_valid", dout_valid, 0);
        chk("reset_dout_lo", dout[31:0], 0);
        chk("reset_dout_hi", 32'(dout[NC*DW-1:32]), 0);
        chk("reset_ptr", ptr, 0);
        chk("reset_sel_err", sel_err, 0);
        chk("reset_frame_done", frame_done, 0);
        reset     = 1'b0;
        din_valid = 1'b0;
        tick();
        chk("post_reset_no_load", dout_valid, 0);

        // manual routing, backpressure and out-of-range table
        for (int i = 0; i < 8; i++) begin
            mode       = vecs[i].mode;
            sel        = vecs[i].sel;
            din        = vecs[i].din;
            din_valid  = vecs[i].dv;
            dout_ready = vecs[i].rdy;
            sample_ready($sformatf("vec%0d_ready", i), vecs[i].exp_ready);
            tick();
            chk($sformatf("vec%0d_valid", i), dout_valid[vecs[i].ch], vecs[i].exp_v);
            chk($sformatf("vec%0d_data", i), ch_data(vecs[i].ch), vecs[i].exp_d);
            chk($sformatf("vec%0d_sel_err", i), sel_err, vecs[i].exp_err);
            chk($sformatf("vec%0d_ptr", i), ptr, 0);
        end

        // drain everything before auto mode
        din_valid  = 1'b0;
        dout_ready = '1;
        tick();
        chk("drain_all", dout_valid, 0);

        // auto round-robin: 30 back-to-back beats, frame_done on wrap
        mode      = 1'b1;
        din_valid = 1'b1;
        for (int k = 0; k < NC; k++) begin
            din = DW'(k);
            sample_ready($sformatf("rr%0d_ready", k), 1'b1);
            tick();
            chk($sformatf("rr%0d_ptr", k), ptr, (k + 1) % NC);
            chk($sformatf("rr%0d_frame_done", k), frame_done, k == NC - 1);
        end
        din_valid = 1'b0;
        tick();
        chk("rr_frame_done_one_cycle", frame_done, 0);
        for (int k = 0; k < NC; k++) begin
            chk($sformatf("rr_data%0d", k), ch_data(k), k);
        end

        // walk ptr to 29, then clear_ptr with an accept in the same cycle
        din_valid = 1'b1;
        din       = 5'h02;
        for (int k = 0; k < NC - 1; k++) tick();
        chk("pre_clear_ptr", ptr, 29);
        chk("pre_clear_fd", frame_done, 0);
        dout_ready = '0;
        clear_ptr  = 1'b1;
        din        = 5'h11;
        sample_ready("clear_ready", 1'b1);
        tick();
        clear_ptr = 1'b0;
        din_valid = 1'b0;
        chk("clear_ch29_valid", dout_valid[29], 1);
        chk("clear_ch29_data", ch_data(29), 5'h11);
        chk("clear_ch0_idle", dout_valid[0], 0);
        chk("clear_ptr", ptr, 0);
        chk("clear_fd", frame_done, 0);
        tick();
        chk("clear_fd_after", frame_done, 0);

        // load channels 0..4, then reset during an accept
        mode      = 1'b0;
        din_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sel = SW'(k);
            din = DW'(k + 1);
            tick();
        end
        chk("pre_reset_valid", dout_valid[4:0], 5'h1F);
        chk("pre_reset_data4", ch_data(4), 5);
        sel   = 5'd6;
        din   = 5'h1E;
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        din_valid = 1'b0;
        chk("midreset_valid", dout_valid, 0);
        chk("midreset_ch6", ch_data(6), 0);
        chk("midreset_ch29", ch_data(29), 0);
        chk("midreset_ptr", ptr, 0);
        chk("midreset_sel_err", sel_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_stream_1_to_n.md
Name: demux_stream_1_to_n

Overview:
- Parametrised, registered successor of the fixed 1-to-30 × 5-bit combinational demux.
- Routes a valid/ready input stream to one of NUM_CH output channels. Each channel has its own holding register and valid/ready handshake.
- Two routing modes: manual (external sel) and auto (internal round-robin pointer with frame-done pulse).
- Sits between a feature-map producer and per-channel convolution/weight buffers.

Parameters:
- DATA_WIDTH, 5, bits per beat.
- NUM_CH, 30, number of output channels (≥2).
- SEL_WIDTH, $clog2(NUM_CH), width of sel and ptr.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- mode  in  1  routing mode: 0 = manual (use sel), 1 = auto (use internal ptr).
- sel  in  SEL_WIDTH  manual target channel, 0-based.
- clear_ptr  in  1  synchronous clear of auto pointer.
- din  in  DATA_WIDTH  input beat.
- din_valid  in  1  input beat valid.
- din_ready  out  1  input may be accepted this cycle.
- dout  out  NUM_CH*DATA_WIDTH  flattened channel registers; channel k at [k*DATA_WIDTH +: DATA_WIDTH].
- dout_valid  out  NUM_CH  per-channel valid.
- dout_ready  in  NUM_CH  per-channel consumer ready.
- ptr  out  SEL_WIDTH  current auto pointer.
- frame_done  out  1  one-cycle pulse on auto pointer wrap.
- sel_err  out  1  sticky flag, manual sel ≥ NUM_CH seen.

Behaviour:
- Reset (sync, highest priority): dout=0, dout_valid=0, ptr=0, frame_done=0, sel_err=0. Any in-flight handshake is discarded.
- Target t = mode ? ptr : sel. The target is in range iff t < NUM_CH; ptr is always in range.
- din_ready is combinational:
  - in range: din_ready = ~dout_valid[t] | dout_ready[t].
  - out of range: din_ready = 1 (beat is sunk).
- accept = din_valid & din_ready.
- Per channel k, each cycle:
  - If dout_valid[k] & dout_ready[k], the channel drains.
  - If accept & t==k & in range: dout[k] <= din, dout_valid[k] <= 1.
  - Else if drained: dout_valid[k] <= 0.
  - Drain and load in the same cycle give back-to-back throughput: valid stays 1 and data is replaced.
  - dout[k] holds its last value after a drain. Data is never cleared except by reset.
- Latency: a beat accepted in cycle n appears on dout/dout_valid in cycle n+1. Sustained rate is 1 beat/cycle when consumers are ready.
- Out-of-range manual beat: dropped, no channel changes, sel_err <= 1. sel_err stays set until reset.
- Auto pointer (advances only on accept with mode=1):
  - ptr <= (ptr==NUM_CH-1) ? 0 : ptr+1.
  - On the wrap, frame_done <= 1 for exactly one cycle; otherwise frame_done <= 0.
- clear_ptr: ptr <= 0, frame_done <= 0. It has priority over increment. A beat accepted in the same cycle still goes to the old ptr.
- In manual mode the pointer does not move. Mode changes are legal any cycle: ptr is retained and takes effect as the target from that cycle.
- Stall: if the target channel is full and not draining, din_ready=0. ptr holds, and din/sel must be held by the producer per valid/ready rules.
- Non-target channels drain independently while the input is stalled.

Test Plan:
- Reset: assert reset 2 cycles with din_valid=1, din=5'h1F -> all dout_valid=0, dout=0, ptr=0, sel_err=0, no load.
- Manual routing: mode=0, all dout_ready=0. Send sel=3,din=5'h0A, then sel=29,din=5'h15 -> cycle+1: dout_valid[3]=1, dout[3]=0x0A; next: dout_valid[29]=1, dout[29]=0x15. A third beat to sel=3 sees din_ready=0 until dout_ready[3] pulses, then loads in the same cycle as the drain.
- Auto round-robin: mode=1, all dout_ready=1, 30 beats din=0..29 back-to-back -> dout[k]=k, ptr returns to 0, frame_done high exactly one cycle after beat 29, throughput 1/cycle.
- Out of range: mode=0, sel=30, din_valid=1 -> din_ready=1, no dout_valid change, sel_err=1 next cycle and sticky through later valid traffic.
- Simultaneous events: mode=1, ptr=29 with clear_ptr=1 and accept in the same cycle -> beat lands in channel 29, ptr=0, frame_done stays 0.
- Mid-operation reset: with 5 channels holding valid data, assert reset during an accept -> all valid=0, that beat is not loaded, ptr=0.
